// File: rtl/mem_load_queue.sv
// MEM-stage tracker for outstanding SRAM-like data requests.
// Responses come back in order and load data is aligned and extended here before WB sees it.
module mem_load_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 37
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_fire,
  input  logic [2:0]               req_op,
  input  logic [1:0]               req_addr_lo,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     can_issue,
  input  logic                     data_ok,
  input  logic [31:0]              rdata,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_data,
  output logic                     resp_is_store,
  output logic [TAG_W-1:0]         resp_tag,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     err_unexp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_DONE} ent_state_e;

  ent_state_e        st_q     [DEPTH];
  logic [DEPTH-1:0]  discard_q;
  logic [2:0]        op_q     [DEPTH];
  logic [1:0]        lo_q     [DEPTH];
  logic [TAG_W-1:0]  tag_q    [DEPTH];
  logic [31:0]       rdata_q  [DEPTH];

  logic [PW-1:0] tail_q, fill_q, head_q, count;
  logic [AW-1:0] tail_idx, fill_idx, head_idx;
  logic          full, alloc, fill_en, retire;

  assign tail_idx = tail_q[AW-1:0];
  assign fill_idx = fill_q[AW-1:0];
  assign head_idx = head_q[AW-1:0];
  assign count    = tail_q - head_q;
  assign full     = (count == PW'(DEPTH));
  assign alloc    = req_fire & ~full;
  assign fill_en  = data_ok & (fill_q != tail_q);
  assign retire   = (head_q != fill_q) & (discard_q[head_idx] | resp_ready);

  assign can_issue   = ~full;
  assign outstanding = count;

  // Control state: pointers, entry states, discard bits, sticky error.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tail_q    <= '0;
      fill_q    <= '0;
      head_q    <= '0;
      discard_q <= '0;
      err_unexp <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) st_q[i] <= ST_FREE;
    end else begin
      if (flush) discard_q <= '1;
      if (retire) begin
        st_q[head_idx] <= ST_FREE;
        head_q         <= head_q + PW'(1);
      end
      if (fill_en) begin
        st_q[fill_idx] <= ST_DONE;
        fill_q         <= fill_q + PW'(1);
      end
      if (alloc) begin
        st_q[tail_idx]      <= ST_WAIT;
        discard_q[tail_idx] <= flush;
        tail_q              <= tail_q + PW'(1);
      end
      if ((req_fire & full) | (data_ok & (fill_q == tail_q))) err_unexp <= 1'b1;
    end
  end

  // Payload storage; only meaningful while the entry is live, so no reset.
  always_ff @(posedge clk) begin
    if (alloc) begin
      op_q[tail_idx]  <= req_op;
      lo_q[tail_idx]  <= req_addr_lo;
      tag_q[tail_idx] <= req_tag;
    end
    if (fill_en) rdata_q[fill_idx] <= rdata;
  end

  logic [31:0] h_rd;
  logic [2:0]  h_op;
  logic [1:0]  h_lo;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Head extraction: byte/half select then sign or zero extension.
  always_comb begin
    h_rd   = rdata_q[head_idx];
    h_op   = op_q[head_idx];
    h_lo   = lo_q[head_idx];
    byte_v = h_rd[7:0];
    case (h_lo)
      2'd1:    byte_v = h_rd[15:8];
      2'd2:    byte_v = h_rd[23:16];
      2'd3:    byte_v = h_rd[31:24];
      default: byte_v = h_rd[7:0];
    endcase
    half_v    = h_lo[1] ? h_rd[31:16] : h_rd[15:0];
    resp_data = h_rd;
    case (h_op)
      3'b001:  resp_data = {{24{byte_v[7]}}, byte_v};
      3'b010:  resp_data = {24'd0, byte_v};
      3'b011:  resp_data = {{16{half_v[15]}}, half_v};
      3'b100:  resp_data = {16'd0, half_v};
      3'b101:  resp_data = 32'd0;
      default: resp_data = h_rd;
    endcase
  end

  assign resp_valid    = (st_q[head_idx] == ST_DONE) & ~discard_q[head_idx];
  assign resp_is_store = (h_op == 3'b101);
  assign resp_tag      = tag_q[head_idx];

endmodule

// File: tb/tb_mem_load_queue.sv
// Directed bench for mem_load_queue; a negedge monitor pops a scoreboard of expected responses.
module tb_mem_load_queue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_fire;
  logic [2:0]  req_op;
  logic [1:0]  req_addr_lo;
  logic [36:0] req_tag;
  logic        can_issue;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_is_store;
  logic [36:0] resp_tag;
  logic [2:0]  outstanding;
  logic        err_unexp;

  typedef struct packed {
    logic [36:0] tag;
    logic [31:0] data;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_load_queue #(.DEPTH(4), .TAG_W(37)) dut (
    .clk(clk), .resetn(resetn), .req_fire(req_fire), .req_op(req_op),
    .req_addr_lo(req_addr_lo), .req_tag(req_tag), .can_issue(can_issue),
    .data_ok(data_ok), .rdata(rdata), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_is_store(resp_is_store),
    .resp_tag(resp_tag), .outstanding(outstanding), .err_unexp(err_unexp)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted response must match the oldest expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got tag 0x%0h data 0x%0h expected none", resp_tag, resp_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_tag", 64'(resp_tag), 64'(e.tag));
        check("resp_data", 64'(resp_data), 64'(e.data));
        check("resp_is_store", 64'(resp_is_store), 64'(e.st));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [36:0] tag, input logic [31:0] data, input logic st);
    exp_t e;
    e.tag  = tag;
    e.data = data;
    e.st   = st;
    exp_q.push_back(e);
  endtask

  task automatic load_one(input logic [2:0] op, input logic [1:0] lo, input logic [36:0] tag,
                          input logic [31:0] rd, input logic [31:0] exp);
    resp_ready  = 1'b1;
    req_fire    = 1'b1;
    req_op      = op;
    req_addr_lo = lo;
    req_tag     = tag;
    expect_resp(tag, exp, op == 3'b101);
    tick();
    req_fire = 1'b0;
    data_ok  = 1'b1;
    rdata    = rd;
    tick();
    data_ok = 1'b0;
    check("resp_valid_latency", 64'(resp_valid), 64'd1);
    tick();
    check("single_drain", 64'(outstanding), 64'd0);
  endtask

  initial begin
    resetn = 1'b0; req_fire = 1'b0; req_op = 3'd0; req_addr_lo = 2'd0; req_tag = '0;
    data_ok = 1'b0; rdata = '0; flush = 1'b0; resp_ready = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_can_issue", 64'(can_issue), 64'd1);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_err", 64'(err_unexp), 64'd0);

    // Extraction patterns
    load_one(3'b001, 2'b11, 37'd1, 32'h80FF_1234, 32'hFFFF_FF80);
    load_one(3'b010, 2'b11, 37'd2, 32'h80FF_1234, 32'h0000_0080);
    load_one(3'b100, 2'b10, 37'd3, 32'h80FF_1234, 32'h0000_80FF);
    load_one(3'b011, 2'b10, 37'd4, 32'h80FF_1234, 32'hFFFF_80FF);
    load_one(3'b001, 2'b00, 37'd5, 32'h80FF_1234, 32'h0000_0034);
    load_one(3'b011, 2'b00, 37'd6, 32'h80FF_9234, 32'hFFFF_9234);
    load_one(3'b000, 2'b01, 37'd7, 32'h80FF_1234, 32'h80FF_1234);
    load_one(3'b101, 2'b00, 37'd8, 32'h80FF_1234, 32'h0000_0000);
    load_one(3'b111, 2'b00, 37'd9, 32'hCAFE_BABE, 32'hCAFE_BABE);

    // Fill to full with responses held back
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_fire = 1'b1; req_op = 3'b000; req_addr_lo = 2'b00; req_tag = 37'(10 + i);
      expect_resp(37'(10 + i), 32'(i + 1), 1'b0);
      tick();
      if (i == 2) check("can_issue_at_3", 64'(can_issue), 64'd1);
    end
    req_fire = 1'b0;
    check("full_can_issue", 64'(can_issue), 64'd0);
    check("full_outstanding", 64'(outstanding), 64'd4);
    for (int i = 0; i < 4; i++) begin
      data_ok = 1'b1; rdata = 32'(i + 1);
      tick();
    end
    data_ok = 1'b0;
    tick(); tick();
    check("held_outstanding", 64'(outstanding), 64'd4);
    check("held_valid", 64'(resp_valid), 64'd1);
    check("held_tag", 64'(resp_tag), 64'd10);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("full_drain", 64'(outstanding), 64'd0);
    check("full_drain_can_issue", 64'(can_issue), 64'd1);

    // Flush drain: two flushed loads must never respond
    for (int i = 0; i < 2; i++) begin
      req_fire = 1'b1; req_op = 3'b000; req_tag = 37'(20 + i);
      tick();
    end
    req_fire = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_ok = 1'b1; rdata = 32'hDEAD_0000 + 32'(i);
      tick();
      check("flushed_no_valid", 64'(resp_valid), 64'd0);
    end
    data_ok = 1'b0;
    tick();
    check("flush_drain", 64'(outstanding), 64'd0);
    load_one(3'b000, 2'b00, 37'd22, 32'h1111_2222, 32'h1111_2222);

    // Flush together with req_fire and data_ok
    req_fire = 1'b1; req_op = 3'b000; req_tag = 37'd30;
    tick();
    req_tag = 37'd31; flush = 1'b1; data_ok = 1'b1; rdata = 32'hBAD0_0030;
    tick();
    req_fire = 1'b0; flush = 1'b0; rdata = 32'hBAD0_0031;
    tick();
    data_ok = 1'b0;
    check("simul_no_valid", 64'(resp_valid), 64'd0);
    tick(); tick(); tick();
    check("simul_drain", 64'(outstanding), 64'd0);
    load_one(3'b010, 2'b01, 37'd32, 32'h0000_5A00, 32'h0000_005A);

    // Streamed loads with toggling back-pressure across pointer wrap
    begin
      int issued = 0;
      int filled = 0;
      int cyc = 0;
      while (!(issued == 12 && filled == 12 && outstanding == 0) && cyc < 200) begin
        req_fire   = (issued < 12) && can_issue;
        req_op     = 3'b000;
        req_tag    = 37'(40 + issued);
        data_ok    = (filled < issued);
        rdata      = 32'h100 + 32'(filled);
        resp_ready = cyc[0];
        if (req_fire) expect_resp(37'(40 + issued), 32'h100 + 32'(issued), 1'b0);
        tick();
        if (req_fire) issued++;
        if (data_ok) filled++;
        cyc++;
      end
      req_fire = 1'b0; data_ok = 1'b0; resp_ready = 1'b1;
      check("stream_issued", 64'(issued), 64'd12);
      check("stream_drained", 64'(outstanding), 64'd0);
      check("stream_err", 64'(err_unexp), 64'd0);
    end

    // Unexpected data_ok, then reset with live entries
    tick();
    data_ok = 1'b1; rdata = 32'h0;
    tick();
    data_ok = 1'b0;
    check("err_set", 64'(err_unexp), 64'd1);
    tick();
    check("err_sticky", 64'(err_unexp), 64'd1);
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req_fire = 1'b1; req_op = 3'b000; req_tag = 37'(60 + i);
      tick();
    end
    req_fire = 1'b0;
    data_ok = 1'b1; rdata = 32'h6060_6060;
    tick();
    data_ok = 1'b0;
    check("pre_rst_outstanding", 64'(outstanding), 64'd3);
    check("pre_rst_valid", 64'(resp_valid), 64'd1);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("mid_rst_outstanding", 64'(outstanding), 64'd0);
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_err", 64'(err_unexp), 64'd0);
    check("mid_rst_can_issue", 64'(can_issue), 64'd1);
    tick();

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
